// File: rtl/ad_sample_pkg.sv
// Shared definitions for the ADC burst sequencer: FSM states and default geometry.
package ad_sample_pkg;

  localparam int unsigned ConvCycDef = 100;
  localparam int unsigned SckHalfDef = 4;
  localparam int unsigned DwDef      = 16;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StShift,
    StGap
  } state_e;

endpackage

// File: rtl/ad_spi_rx.sv
// Serial ADC read-out: generates Dw SCK pulses after i_start and shifts SDO in MSB first.
module ad_spi_rx #(
  parameter int unsigned SckHalf = 4,
  parameter int unsigned Dw      = 16
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_sdo,
  output logic          o_sck,
  output logic          o_vld,
  output logic [Dw-1:0] o_data
);

  localparam int unsigned DivW  = (SckHalf > 1) ? $clog2(SckHalf) : 1;
  localparam int unsigned EdgeW = $clog2(2 * Dw + 1);

  logic             r_active;
  logic [DivW-1:0]  r_div;
  logic [EdgeW-1:0] r_edge;
  logic             r_sck;
  logic [Dw-1:0]    r_shift;
  logic [Dw-1:0]    r_data;
  logic             r_fin;
  logic             r_vld;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_div    <= '0;
      r_edge   <= '0;
      r_sck    <= 1'b0;
      r_shift  <= '0;
      r_data   <= '0;
      r_fin    <= 1'b0;
      r_vld    <= 1'b0;
    end else begin
      // Result is published the cycle after the last falling SCK edge.
      r_vld <= r_fin;
      r_fin <= 1'b0;
      if (r_fin) r_data <= r_shift;
      if (!r_active) begin
        if (i_start) begin
          r_active <= 1'b1;
          r_div    <= '0;
          r_edge   <= '0;
          r_sck    <= 1'b0;
        end
      end else if (r_div == DivW'(SckHalf - 1)) begin
        r_div <= '0;
        r_sck <= ~r_sck;
        if (!r_sck) r_shift <= {r_shift[Dw-2:0], i_sdo};
        if (r_edge == EdgeW'(2 * Dw - 1)) begin
          r_active <= 1'b0;
          r_fin    <= 1'b1;
          r_edge   <= '0;
        end else begin
          r_edge <= r_edge + EdgeW'(1);
        end
      end else begin
        r_div <= r_div + DivW'(1);
      end
    end
  end

  assign o_sck  = r_sck;
  assign o_vld  = r_vld;
  assign o_data = r_data;

endmodule

// File: rtl/ad_sample.sv
// ADC burst sequencer: synchronises the trigger, runs CONV/SHIFT/GAP for cfg_num conversions.
module ad_sample
  import ad_sample_pkg::*;
#(
  parameter int unsigned ConvCyc = ConvCycDef,
  parameter int unsigned SckHalf = SckHalfDef,
  parameter int unsigned Dw      = DwDef
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          pluse_us,
  input  logic          ast,
  input  logic [7:0]    cfg_num,
  input  logic [15:0]   cfg_itv,
  output logic          ad_cnv,
  output logic          ad_sck,
  input  logic          ad_sdo,
  output logic [Dw-1:0] ad_data,
  output logic          ad_vld,
  output logic          busy
);

  localparam int unsigned CycW = (ConvCyc > 1) ? $clog2(ConvCyc) : 1;

  logic            r_ast_s1, r_ast_s2, r_ast_prev;
  logic            w_start;
  state_e          r_state, w_state_nxt;
  logic [7:0]      r_num, r_done;
  logic [15:0]     r_itv, r_gap;
  logic [CycW-1:0] r_cyc;
  logic            r_cnv, r_busy;
  logic            w_spi_start;
  logic            w_vld;

  assign w_start     = r_ast_s2 & ~r_ast_prev;
  assign w_spi_start = (r_state == StConv) && (r_cyc == CycW'(ConvCyc - 1));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_ast_s1   <= 1'b0;
      r_ast_s2   <= 1'b0;
      r_ast_prev <= 1'b0;
    end else begin
      r_ast_s1   <= ast;
      r_ast_s2   <= r_ast_s1;
      r_ast_prev <= r_ast_s2;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_start && (cfg_num != 8'd0)) w_state_nxt = StConv;
      StConv:  if (w_spi_start) w_state_nxt = StShift;
      StShift: begin
        if (w_vld) begin
          if (r_done + 8'd1 == r_num) w_state_nxt = StIdle;
          else if (r_itv == 16'd0)    w_state_nxt = StConv;
          else                        w_state_nxt = StGap;
        end
      end
      StGap:   if (pluse_us && (r_gap + 16'd1 == r_itv)) w_state_nxt = StConv;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_num   <= '0;
      r_itv   <= '0;
      r_done  <= '0;
      r_gap   <= '0;
      r_cyc   <= '0;
      r_cnv   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Outputs registered from next state so they are glitch-free at the pins.
      r_cnv   <= (w_state_nxt == StConv);
      r_busy  <= (w_state_nxt != StIdle);
      if (r_state == StIdle && w_state_nxt == StConv) begin
        r_num  <= cfg_num;
        r_itv  <= cfg_itv;
        r_done <= '0;
      end
      if (r_state == StShift && w_vld) r_done <= r_done + 8'd1;
      if (r_state == StConv && !w_spi_start) r_cyc <= r_cyc + CycW'(1);
      else                                   r_cyc <= '0;
      if (r_state != StGap) r_gap <= '0;
      else if (pluse_us)    r_gap <= r_gap + 16'd1;
    end
  end

  ad_spi_rx #(
    .SckHalf (SckHalf),
    .Dw      (Dw)
  ) u_spi_rx (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .i_start (w_spi_start),
    .i_sdo   (ad_sdo),
    .o_sck   (ad_sck),
    .o_vld   (w_vld),
    .o_data  (ad_data)
  );

  assign ad_cnv = r_cnv;
  assign ad_vld = w_vld;
  assign busy   = r_busy;

endmodule
